// File: rtl/sram.sv
// sram - behavioural model of a 256K x 16 asynchronous SRAM (IS61LV25616-class)
//
// Sits beside the processor top level and answers its SRAM controller over the
// active-low SRAM_* pins. Writes commit on the rising clock edge. Reads are
// combinational: data follows the address and the enables with no added latency.
//
// Ports
//   clk        in     1        system clock; writes commit on rising edge
//   rst        in     1        synchronous reset, active-low
//   SRAM_UB_N  in     1        upper byte lane enable, active-low (DQ[15:8])
//   SRAM_LB_N  in     1        lower byte lane enable, active-low (DQ[7:0])
//   SRAM_WE_N  in     1        write enable, active-low
//   SRAM_CE_N  in     1        chip enable, active-low
//   SRAM_OE_N  in     1        output enable, active-low
//   SRAM_DQ    inout  DATA_W   shared bidirectional data bus
//   SRAM_ADDR  in     ADDR_W   word address (full range valid, no wrap)
//
// Array contents are not touched by reset. Every word starts at INIT_VAL.
// A non-empty INIT_FILE stops elaboration, because this model carries no
// file preload path.

module sram #(
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned DATA_W    = 16,
    parameter string       INIT_FILE = "",
    parameter logic [15:0] INIT_VAL  = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SRAM_UB_N,
    input  logic              SRAM_LB_N,
    input  logic              SRAM_WE_N,
    input  logic              SRAM_CE_N,
    input  logic              SRAM_OE_N,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    input  logic [ADDR_W-1:0] SRAM_ADDR
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned LANE_W = DATA_W / 2;

    if (INIT_FILE != "") begin : g_init_file_check
        $error("sram: INIT_FILE preload is not supported; use INIT_VAL");
    end

    logic [DATA_W-1:0] mem [DEPTH] = '{default: DATA_W'(INIT_VAL)};

    // Set by any edge that samples rst low.
    // Cleared by the first edge that samples rst high.
    logic rst_flag;

    logic              addr_unknown;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] rd_word;

    always_ff @(posedge clk) begin
        rst_flag <= ~rst;
    end

    assign addr_unknown = $isunknown(SRAM_ADDR);

    // An edge that samples rst low must not commit.
    // The edge that releases reset must not commit either, because the flag is
    // still set at that edge.
    assign wr_en = rst && !rst_flag && !SRAM_CE_N && !SRAM_WE_N;

    // WE_N low always wins over OE_N, so the model never fights the
    // controller while the controller drives write data.
    assign rd_en = !rst_flag && !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;

    always_ff @(posedge clk) begin
        if (wr_en && !addr_unknown) begin
            if (!SRAM_LB_N) begin
                mem[SRAM_ADDR][LANE_W-1:0] <= SRAM_DQ[LANE_W-1:0];
            end
            if (!SRAM_UB_N) begin
                mem[SRAM_ADDR][DATA_W-1:LANE_W] <= SRAM_DQ[DATA_W-1:LANE_W];
            end
        end
    end

    always_comb begin
        rd_word = mem[SRAM_ADDR];
        if (addr_unknown) begin
            rd_word = 'x;
        end
    end

    assign SRAM_DQ[LANE_W-1:0] = (rd_en && !SRAM_LB_N)
                               ? rd_word[LANE_W-1:0]
                               : {LANE_W{1'bz}};

    assign SRAM_DQ[DATA_W-1:LANE_W] = (rd_en && !SRAM_UB_N)
                                    ? rd_word[DATA_W-1:LANE_W]
                                    : {(DATA_W - LANE_W){1'bz}};

endmodule

// File: tb/tb_sram.sv
// tb_sram - scoreboard bench for the sram behavioural model.
// The bus carries a pull-up, so an undriven lane reads back as 8'hFF.
// No test data uses 8'hFF, so a released lane cannot be confused with a
// stored value.

module tb_sram;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ub_n = 1'b1;
    logic        lb_n = 1'b1;
    logic        we_n = 1'b1;
    logic        ce_n = 1'b1;
    logic        oe_n = 1'b1;
    logic [17:0] addr = '0;
    logic        tb_drive = 1'b0;
    logic [15:0] tb_dq = '0;
    wire  [15:0] dq;

    assign dq = tb_drive ? tb_dq : 16'bz;
    pullup (dq);

    sram #(
        .ADDR_W    (18),
        .DATA_W    (16),
        .INIT_FILE (""),
        .INIT_VAL  (16'h0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .SRAM_UB_N (ub_n),
        .SRAM_LB_N (lb_n),
        .SRAM_WE_N (we_n),
        .SRAM_CE_N (ce_n),
        .SRAM_OE_N (oe_n),
        .SRAM_DQ   (dq),
        .SRAM_ADDR (addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t queue_exp[$];
    event sample_ev;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Monitor: compares the bus against the oldest expectation.
    initial begin
        forever begin
            @(sample_ev);
            if (queue_exp.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_sample: got %h, no expectation queued", dq);
            end else begin
                exp_t e;
                e = queue_exp.pop_front();
                n_checks++;
                if (dq !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h, expected %h", e.name, dq, e.exp);
                end
            end
        end
    end

    task automatic idle_pins();
        we_n     = 1'b1;
        oe_n     = 1'b1;
        ce_n     = 1'b1;
        ub_n     = 1'b1;
        lb_n     = 1'b1;
        tb_drive = 1'b0;
    endtask

    // Sets up the bus pins after a falling edge and commits on the next rising edge.
    task automatic do_write(input logic [17:0] a, input logic [15:0] d,
                            input logic ub, input logic lb,
                            input logic ce, input logic oe);
        @(negedge clk);
        addr     = a;
        tb_dq    = d;
        tb_drive = 1'b1;
        ub_n     = ub;
        lb_n     = lb;
        ce_n     = ce;
        oe_n     = oe;
        we_n     = 1'b0;
        @(posedge clk);
        #1;
        idle_pins();
    endtask

    // Sets up the read pins, queues the expected bus value and requests a sample.
    task automatic do_read(input logic [17:0] a, input logic ub, input logic lb,
                           input logic ce, input logic oe,
                           input logic [15:0] exp, input string name);
        exp_t e;
        @(negedge clk);
        tb_drive = 1'b0;
        we_n     = 1'b1;
        addr     = a;
        ub_n     = ub;
        lb_n     = lb;
        ce_n     = ce;
        oe_n     = oe;
        #1;
        e.exp  = exp;
        e.name = name;
        queue_exp.push_back(e);
        -> sample_ev;
        #1;
    endtask

    initial begin
        // Hold reset for two edges with the read pins asserted; the bus must stay released.
        idle_pins();
        rst  = 1'b0;
        ce_n = 1'b0;
        oe_n = 1'b0;
        ub_n = 1'b0;
        lb_n = 1'b0;
        addr = 18'h00010;
        repeat (2) @(posedge clk);
        do_read(18'h00010, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, "reset_hiz");

        // Release reset. Data comes from INIT_VAL.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        do_read(18'h00010, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "post_reset_read");

        // Full-word write, then partial-lane writes and reads.
        do_write(18'h00010, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1);
        do_read(18'h00010, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF, "write_read_beef");
        do_write(18'h00010, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1);
        do_read(18'h00010, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBE34, "lb_only_write");
        do_read(18'h00010, 1'b0, 1'b1, 1'b0, 1'b0, 16'hBEFF, "read_lb_off");
        do_read(18'h00010, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFF34, "read_ub_off");

        // Both lanes disabled: the word must not change.
        do_write(18'h00010, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
        do_read(18'h00010, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBE34, "no_lane_write");

        // Chip disabled: the write is ignored and the bus stays released.
        do_write(18'h3FFFF, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b1);
        do_read(18'h3FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "ce_off_write");
        do_read(18'h3FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF, "ce_off_hiz");
        do_read(18'h00010, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, "oe_off_hiz");

        // Both address extremes.
        do_write(18'h3FFFF, 16'hA5A5, 1'b0, 1'b0, 1'b0, 1'b1);
        do_write(18'h00000, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b1);
        do_read(18'h3FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA5A5, "top_addr");
        do_read(18'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0F0F, "bottom_addr");

        // The read data follows an address change with no clock edge in between.
        do_read(18'h3FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA5A5, "addr_follow_a");
        #1;
        addr = 18'h00000;
        #1;
        begin
            exp_t e;
            e.exp  = 16'h0F0F;
            e.name = "addr_follow_b";
            queue_exp.push_back(e);
            -> sample_ev;
        end
        #1;

        // WE_N low with OE_N low still writes.
        do_write(18'h00020, 16'hC3C3, 1'b0, 1'b0, 1'b0, 1'b0);
        do_read(18'h00020, 1'b0, 1'b0, 1'b0, 1'b0, 16'hC3C3, "we_oe_write");

        // A write pending during reset does not commit.
        // The write still must not commit on the edge that releases reset.
        @(negedge clk);
        rst = 1'b0;
        do_write(18'h00010, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst      = 1'b1;
        addr     = 18'h00010;
        tb_dq    = 16'h2222;
        tb_drive = 1'b1;
        ub_n     = 1'b0;
        lb_n     = 1'b0;
        ce_n     = 1'b0;
        we_n     = 1'b0;
        @(posedge clk);
        #1;
        idle_pins();
        do_read(18'h00010, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBE34, "reset_write_blocked");
        do_read(18'h3FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA5A5, "reset_keeps_mem");

        // Give the monitor a bounded number of cycles to drain the queue.
        for (int i = 0; i < 10 && queue_exp.size() != 0; i++) @(posedge clk);
        while (queue_exp.size() != 0) begin
            exp_t e;
            e = queue_exp.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no sample, expected %h", e.name, e.exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
